// File: rtl/multi_debouncer_pkg.sv
// Shared timing defaults, hold-phase type and counter sizing for the front-panel debouncer.
package multi_debouncer_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
  localparam int DEF_HOLD_CYCLES     = CLK_HZ / 2;    // 0.5 s
  localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;    // 0.2 s

  typedef enum logic {
    PH_FIRST,
    PH_REPEAT
  } hold_phase_e;

  // Width that holds the largest of the three cycle counts without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_ch.sv
// One debounce channel: synchroniser, stability counter, hold/repeat counter, registered pulses.
module multi_debouncer_ch
  import multi_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int   REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter logic ACTIVE_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic hold
);

  localparam int W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic           IDLE        = ~ACTIVE_LEVEL;
  localparam logic [W-1:0]   DEB_LAST    = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0]   HOLD_LAST   = W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [W-1:0]   REPEAT_LAST = W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic        s0, s1;
  logic [W-1:0] stab_cnt;
  logic [W-1:0] hold_cnt;
  hold_phase_e  phase;
  logic         accept;

  // The synchronised input has been different from level long enough to be taken.
  always_comb begin
    accept = (s1 != level) && (stab_cnt == DEB_LAST);
  end

  // NOTE: every state register below uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0            <= IDLE;
      s1            <= IDLE;
      level         <= IDLE;
      stab_cnt      <= '0;
      hold_cnt      <= '0;
      phase         <= PH_FIRST;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      hold          <= 1'b0;
    end else begin
      s0            <= sw;
      s1            <= s0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      hold          <= 1'b0;

      if (s1 == level) begin
        stab_cnt <= '0;
      end else if (accept) begin
        level    <= s1;
        stab_cnt <= '0;
        if (s1 == ACTIVE_LEVEL) press <= 1'b1;
        else                    release_pulse <= 1'b1;
      end else if (stab_cnt != '1) begin
        stab_cnt <= stab_cnt + W'(1);
      end

      // A release edge counts as idle so hold can never share a cycle with release.
      if (level != ACTIVE_LEVEL || accept) begin
        hold_cnt <= '0;
        phase    <= PH_FIRST;
      end else if (HOLD_CYCLES != 0) begin
        case (phase)
          PH_FIRST: begin
            if (hold_cnt == HOLD_LAST) begin
              hold     <= 1'b1;
              hold_cnt <= '0;
              phase    <= PH_REPEAT;
            end else if (hold_cnt != '1) begin
              hold_cnt <= hold_cnt + W'(1);
            end
          end
          PH_REPEAT: begin
            if (REPEAT_CYCLES != 0) begin
              if (hold_cnt == REPEAT_LAST) begin
                hold     <= 1'b1;
                hold_cnt <= '0;
              end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + W'(1);
              end
            end
          end
          default: phase <= PH_FIRST;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// N independent front-panel debounce channels; release is a reserved word, hence release_pulse.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int   N_CH            = 4,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int   REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter logic ACTIVE_LEVEL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] hold
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    multi_debouncer_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LEVEL   (ACTIVE_LEVEL)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .sw           (sw_in[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .hold         (hold[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench: each scenario queues the per-cycle expected outputs, then drains them against the DUT.
module tb_multi_debouncer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  logic [3:0] level, press, rel, hold;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] hold;
  } obs_t;

  obs_t       exp_q[$];
  logic [3:0] cur_lvl;
  int         n_tests;
  int         n_fail;

  multi_debouncer #(
    .N_CH           (4),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .ACTIVE_LEVEL   (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_in        (sw_in),
    .level        (level),
    .press        (press),
    .release_pulse(rel),
    .hold         (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry 0 of a window is the output after the first posedge following the stimulus.
  function automatic void push_window(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.level = cur_lvl;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void mark(input int idx, input int kind, input int ch);
    case (kind)
      0:       exp_q[idx].press[ch] = 1'b1;
      1:       exp_q[idx].rel[ch]   = 1'b1;
      default: exp_q[idx].hold[ch]  = 1'b1;
    endcase
  endfunction

  function automatic void set_level(input int from, input int ch, input logic v);
    for (int i = from; i < exp_q.size(); i++) exp_q[i].level[ch] = v;
    cur_lvl[ch] = v;
  endfunction

  task automatic drain(input string name);
    obs_t got, e;
    int   idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      got.level = level;
      got.press = press;
      got.rel   = rel;
      got.hold  = hold;
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got level=%h press=%h release=%h hold=%h, expected level=%h press=%h release=%h hold=%h",
                 name, idx, got.level, got.press, got.rel, got.hold, e.level, e.press, e.rel, e.hold);
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    sw_in   = 4'hF;
    cur_lvl = 4'hF;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({level, press, rel, hold} !== {4'hF, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_state: got %h, expected %h", {level, press, rel, hold}, {4'hF, 12'h000});
    end
    rst_n = 1'b1;
    push_window(8);
    drain("reset_idle");
  endtask

  task automatic test_clean_press();
    sw_in[0] = 1'b0;
    push_window(12);
    mark(5, 0, 0);
    set_level(5, 0, 1'b0);
    drain("clean_press");
  endtask

  task automatic test_release();
    // Press landed 7 edges before this window, so the first hold falls at entry 3.
    sw_in[0] = 1'b1;
    push_window(20);
    mark(3, 2, 0);
    mark(5, 1, 0);
    set_level(5, 0, 1'b1);
    drain("release");
  endtask

  task automatic test_bounce();
    push_window(50);
    fork
      drain("bounce");
      begin
        for (int i = 0; i < 40; i++) begin
          sw_in[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
          @(negedge clk);
        end
        sw_in[1] = 1'b1;
      end
    join
  endtask

  task automatic test_hold_repeat();
    sw_in[2] = 1'b0;
    push_window(55);
    mark(5, 0, 2);
    set_level(5, 2, 1'b0);
    for (int off = 10; off < 35; off += 3) mark(5 + off, 2, 2);
    mark(40, 1, 2);
    set_level(40, 2, 1'b1);
    fork
      drain("hold_repeat");
      begin
        repeat (35) @(negedge clk);
        sw_in[2] = 1'b1;
      end
    join
  endtask

  task automatic test_independence();
    sw_in[0] = 1'b0;
    sw_in[3] = 1'b0;
    push_window(20);
    mark(5, 0, 0);
    mark(5, 0, 3);
    set_level(5, 0, 1'b0);
    set_level(5, 3, 1'b0);
    mark(13, 1, 0);
    mark(13, 1, 3);
    set_level(13, 0, 1'b1);
    set_level(13, 3, 1'b1);
    fork
      drain("independence");
      begin
        repeat (8) @(negedge clk);
        sw_in[0] = 1'b1;
        sw_in[3] = 1'b1;
      end
    join
  endtask

  task automatic test_reset_mid();
    sw_in[0] = 1'b0;
    push_window(4);
    drain("pre_reset");
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({level, press, rel, hold} !== {4'hF, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_mid_immediate: got %h, expected %h", {level, press, rel, hold}, {4'hF, 12'h000});
    end
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({level, press, rel, hold} !== {4'hF, 12'h000}) begin
        n_fail++;
        $display("FAIL reset_mid_held: got %h, expected %h", {level, press, rel, hold}, {4'hF, 12'h000});
      end
    end
    rst_n = 1'b1;
    push_window(12);
    mark(5, 0, 0);
    set_level(5, 0, 1'b0);
    drain("post_reset_press");
    sw_in[0] = 1'b1;
    push_window(10);
    mark(3, 2, 0);
    mark(5, 1, 0);
    set_level(5, 0, 1'b1);
    drain("post_reset_release");
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_hold_repeat();
    test_independence();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
